piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer_pkg.sv | 12 +
 rtl/piso_serializer.sv | 107 ++++++++++
 tb/tb_piso_serializer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer: state encoding
// and the default parallel word width.
package piso_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding register so that
// back-to-back words stream with no idle cycle between them.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no word in flight; dout parked at IDLE_BIT
// SHIFT | shifter driving dout, bitcnt = index of the bit on the line
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int   WIDTH     = DEFAULT_WIDTH,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             frame_last,
   output logic             busy
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shifter, shifter_nxt;
   logic [WIDTH-1:0] hold, hold_nxt;
   logic [CW-1:0]    bitcnt, bitcnt_nxt;
   logic             hold_full, hold_full_nxt;
   logic             accept;
   logic [WIDTH-1:0] shifted;

   assign load_ready = ~hold_full;
   assign accept     = load_valid & load_ready;

   // Shift toward whichever end feeds dout.
   assign shifted = MSB_FIRST ? {shifter[WIDTH-2:0], 1'b0}
                              : {1'b0, shifter[WIDTH-1:1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shifter   <= '0;
         hold      <= '0;
         bitcnt    <= '0;
         hold_full <= 1'b0;
      end else begin
         state     <= state_nxt;
         shifter   <= shifter_nxt;
         hold      <= hold_nxt;
         bitcnt    <= bitcnt_nxt;
         hold_full <= hold_full_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      shifter_nxt   = shifter;
      hold_nxt      = hold;
      bitcnt_nxt    = bitcnt;
      hold_full_nxt = hold_full;
      case (state)
         IDLE: begin
            if (accept) begin
               shifter_nxt = data_in;
               bitcnt_nxt  = '0;
               state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            if (bitcnt != LAST) begin
               shifter_nxt = shifted;
               bitcnt_nxt  = bitcnt + CW'(1);
               if (accept) begin
                  hold_nxt      = data_in;
                  hold_full_nxt = 1'b1;
               end
            end else if (hold_full) begin
               // Held word goes first; load_ready is low so no new accept can race it.
               shifter_nxt   = hold;
               hold_full_nxt = 1'b0;
               bitcnt_nxt    = '0;
            end else if (accept) begin
               shifter_nxt = data_in;
               bitcnt_nxt  = '0;
            end else begin
               bitcnt_nxt = '0;
               state_nxt  = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign dout_valid = (state == SHIFT);
   assign frame_last = (state == SHIFT) && (bitcnt == LAST);
   assign busy       = (state == SHIFT) || hold_full;
   assign dout       = (state == SHIFT) ? (MSB_FIRST ? shifter[WIDTH-1] : shifter[0])
                                        : IDLE_BIT;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: default 8-bit MSB-first instance plus a 4-bit LSB-first
// instance, table-driven single words and hand-written multi-cycle sequences.
module tb_piso_serializer;

   logic       clk;
   logic       reset;
   logic [7:0] data_a;
   logic       lv_a, lr_a, dout_a, dv_a, fl_a, busy_a;
   logic [3:0] data_b;
   logic       lv_b, lr_b, dout_b, dv_b, fl_b, busy_b;

   int n_cmp = 0;
   int n_err = 0;

   piso_serializer dut_a (
      .clk(clk), .reset(reset), .data_in(data_a), .load_valid(lv_a),
      .load_ready(lr_a), .dout(dout_a), .dout_valid(dv_a),
      .frame_last(fl_a), .busy(busy_a)
   );

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
      .clk(clk), .reset(reset), .data_in(data_b), .load_valid(lv_b),
      .load_ready(lr_b), .dout(dout_b), .dout_valid(dv_b),
      .frame_last(fl_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] word;
      logic [7:0] seq;   // expected dout order, first bit in [7]
   } vec8_t;

   typedef struct {
      logic [3:0] word;
      logic [3:0] seq;   // expected dout order, first bit in [3]
   } vec4_t;

   vec8_t v8[4];
   vec4_t v4[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_idle_a(input string tag);
      chk({tag, "_dout"}, 32'(dout_a), 32'h0);
      chk({tag, "_valid"}, 32'(dv_a), 32'h0);
      chk({tag, "_last"}, 32'(fl_a), 32'h0);
      chk({tag, "_busy"}, 32'(busy_a), 32'h0);
      chk({tag, "_ready"}, 32'(lr_a), 32'h1);
   endtask

   // Checks 8 bits starting with the bit already on the line.
   task automatic stream8(input logic [7:0] seq, input string tag);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s_bit%0d", tag, i), 32'(dout_a), 32'(seq[7-i]));
         chk($sformatf("%s_valid%0d", tag, i), 32'(dv_a), 32'h1);
         chk($sformatf("%s_last%0d", tag, i), 32'(fl_a), (i == 7) ? 32'h1 : 32'h0);
         tick();
      end
   endtask

   task automatic send8(input logic [7:0] word, input logic [7:0] seq, input string tag);
      data_a = word;
      lv_a   = 1'b1;
      tick();
      lv_a = 1'b0;
      stream8(seq, tag);
      chk_idle_a({tag, "_end"});
   endtask

   task automatic send4(input logic [3:0] word, input logic [3:0] seq, input string tag);
      data_b = word;
      lv_b   = 1'b1;
      tick();
      lv_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s_bit%0d", tag, i), 32'(dout_b), 32'(seq[3-i]));
         chk($sformatf("%s_valid%0d", tag, i), 32'(dv_b), 32'h1);
         chk($sformatf("%s_last%0d", tag, i), 32'(fl_b), (i == 3) ? 32'h1 : 32'h0);
         tick();
      end
      chk({tag, "_end_valid"}, 32'(dv_b), 32'h0);
      chk({tag, "_end_dout"}, 32'(dout_b), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] seq16;
      logic [3:0]  det;
      int          hits, hp0, hp1;
      logic [7:0]  w5[5];
      logic [7:0]  cur;
      int          idx, nout, vcount, first_v, last_v;
      logic        acc;

      v8[0] = '{8'hA5, 8'b1010_0101};
      v8[1] = '{8'h3C, 8'b0011_1100};
      v8[2] = '{8'h01, 8'b0000_0001};
      v8[3] = '{8'h80, 8'b1000_0000};
      v4[0] = '{4'b0011, 4'b1100};
      v4[1] = '{4'b0001, 4'b1000};
      v4[2] = '{4'b1010, 4'b0101};
      v4[3] = '{4'b1110, 4'b0111};

      reset  = 1'b1;
      data_a = '0;
      lv_a   = 1'b0;
      data_b = '0;
      lv_b   = 1'b0;
      #2;
      chk_idle_a("rst");
      chk("rst_b_ready", 32'(lr_b), 32'h1);
      chk("rst_b_valid", 32'(dv_b), 32'h0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk_idle_a("post_rst");

      for (int k = 0; k < 4; k++)
         send8(v8[k].word, v8[k].seq, $sformatf("v8_%0d", k));
      for (int k = 0; k < 4; k++)
         send4(v4[k].word, v4[k].seq, $sformatf("v4_%0d", k));

      // Two A0 words back to back, with a 1010 detector on the stream.
      seq16 = 16'hA0A0;
      det   = 4'b0;
      hits  = 0;
      hp0   = -1;
      hp1   = -1;
      data_a = 8'hA0;
      lv_a   = 1'b1;
      tick();
      for (int c = 0; c < 16; c++) begin
         if (c == 0) chk("a0_ready_first", 32'(lr_a), 32'h1);
         if (c == 1) begin
            chk("a0_ready_held", 32'(lr_a), 32'h0);
            chk("a0_busy_held", 32'(busy_a), 32'h1);
            lv_a = 1'b0;
         end
         chk($sformatf("a0_valid%0d", c), 32'(dv_a), 32'h1);
         chk($sformatf("a0_bit%0d", c), 32'(dout_a), 32'(seq16[15-c]));
         det = {det[2:0], dout_a};
         if (det == 4'b1010) begin
            if (hits == 0) hp0 = c;
            else if (hits == 1) hp1 = c;
            hits++;
         end
         tick();
      end
      chk("a0_det_hits", 32'(hits), 32'd2);
      chk("a0_det_pos0", 32'(hp0), 32'd3);
      chk("a0_det_pos1", 32'(hp1), 32'd11);
      chk_idle_a("a0_end");

      // Five words with load_valid held high throughout.
      w5[0] = 8'h11; w5[1] = 8'h9E; w5[2] = 8'h33; w5[3] = 8'hC4; w5[4] = 8'h5A;
      idx     = 0;
      nout    = 0;
      vcount  = 0;
      first_v = -1;
      last_v  = -1;
      cur     = '0;
      data_a  = w5[0];
      lv_a    = 1'b1;
      for (int c = 0; c < 60; c++) begin
         acc = lv_a && lr_a;
         if (c == 0) chk("w5_ready_first", 32'(lr_a), 32'h1);
         tick();
         if (acc) begin
            idx++;
            if (idx == 2) chk("w5_ready_full", 32'(lr_a), 32'h0);
            if (idx < 5) data_a = w5[idx];
            else lv_a = 1'b0;
         end
         if (dv_a) begin
            vcount++;
            if (first_v < 0) first_v = c;
            last_v = c;
            cur = {cur[6:0], dout_a};
            if (fl_a) begin
               if (nout < 5) chk($sformatf("w5_word%0d", nout), 32'(cur), 32'(w5[nout]));
               nout++;
            end
         end
      end
      chk("w5_accepted", 32'(idx), 32'd5);
      chk("w5_words_out", 32'(nout), 32'd5);
      chk("w5_valid_bits", 32'(vcount), 32'd40);
      chk("w5_no_gap", 32'(last_v - first_v + 1), 32'd40);
      chk_idle_a("w5_end");

      // Accept exactly on the last-bit cycle with the holding register empty.
      data_a = 8'hC3;
      lv_a   = 1'b1;
      tick();
      lv_a = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("lb_frame_last", 32'(fl_a), 32'h1);
      chk("lb_ready", 32'(lr_a), 32'h1);
      chk("lb_bit7", 32'(dout_a), 32'h1);
      data_a = 8'h3C;
      lv_a   = 1'b1;
      tick();
      lv_a = 1'b0;
      stream8(8'b0011_1100, "lb_next");
      chk_idle_a("lb_end");

      // Reset in the middle of a word.
      data_a = 8'hFF;
      lv_a   = 1'b1;
      tick();
      lv_a = 1'b0;
      tick();
      tick();
      tick();
      chk("mr_bit3", 32'(dout_a), 32'h1);
      chk("mr_valid3", 32'(dv_a), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      chk_idle_a("mr_async");
      tick();
      reset = 1'b0;
      tick();
      chk_idle_a("mr_release");
      send8(8'h0F, 8'b0000_1111, "mr_after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
